// File: rtl/fpu_wb_queue_pkg.sv
// fpu_pkg: shared types and constants for the FPU writeback queue.
//   FP_DATA_W / FP_REG_ADDR_W : result and register-index widths of a stored entry
//   fp_wb_entry_t             : one buffered FPU result
//   q_state_t / queue_state() : EMPTY / PARTIAL / FULL occupancy view derived from count
package fpu_pkg;

    localparam int FP_DATA_W     = 32;
    localparam int FP_REG_ADDR_W = 5;

    typedef struct packed {
        logic [FP_DATA_W-1:0]     result;
        logic [FP_REG_ADDR_W-1:0] rd;
        logic                     to_int;
        logic                     ovf;
    } fp_wb_entry_t;

    typedef enum logic [1:0] {
        Q_EMPTY   = 2'd0,
        Q_PARTIAL = 2'd1,
        Q_FULL    = 2'd2
    } q_state_t;

    function automatic q_state_t queue_state(input int cnt, input int depth);
        if (cnt == 0) begin
            return Q_EMPTY;
        end else if (cnt >= depth) begin
            return Q_FULL;
        end
        return Q_PARTIAL;
    endfunction

endpackage

// File: rtl/fpu_wb_queue_if.sv
// fpu_wb_queue_if: enqueue (FPU side) and dequeue (writeback side) handshake bundle.
//   in_valid/in_ready/in_result/in_ovf/in_rd/in_to_int : FPU result into the queue
//   out_valid/out_ready/out_result/out_rd/out_to_int   : head entry to register-file writeback
//   modport slave  : the queue
//   modport master : the surrounding pipeline (FPU producer + writeback consumer)
interface fpu_wb_queue_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_result;
    logic                  in_ovf;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_to_int;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_result;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_to_int;

    modport slave (
        input  in_valid, in_result, in_ovf, in_rd, in_to_int, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_to_int
    );

    modport master (
        output in_valid, in_result, in_ovf, in_rd, in_to_int, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_to_int
    );

endinterface

// File: rtl/fpu_wb_queue_mem.sv
// fpu_wb_mem: DEPTH x fp_wb_entry_t register array for the writeback queue.
//   clk, rstn          : clock, async active-low reset (clears every entry)
//   wr_en/wr_ptr/wr_data : single write port
//   rd_ptr/rd_data     : asynchronous read port (head entry)
//   tap_rd/tap_to_int  : per-entry destination taps for the decode hazard lookup
module fpu_wb_mem
    import fpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                wr_en,
    input  logic [PTR_W-1:0]                    wr_ptr,
    input  fp_wb_entry_t                        wr_data,
    input  logic [PTR_W-1:0]                    rd_ptr,
    output fp_wb_entry_t                        rd_data,
    output logic [DEPTH-1:0][FP_REG_ADDR_W-1:0] tap_rd,
    output logic [DEPTH-1:0]                    tap_to_int
);

    fp_wb_entry_t mem [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

    for (genvar g = 0; g < DEPTH; g++) begin : g_tap
        assign tap_rd[g]     = mem[g].rd;
        assign tap_to_int[g] = mem[g].to_int;
    end

endmodule

// File: rtl/fpu_wb_queue.sv
// fpu_wb_queue: in-order result buffer between the combinational FPU and the
// register-file writeback port.
//   clk, rstn    : clock, async active-low reset
//   wb (slave)   : in_* enqueue handshake from the FPU, out_* head entry to writeback
//   flush        : drop all entries (and any same-cycle input)
//   ovf_sticky   : OR of in_ovf over accepted results; ovf_clr clears it (set wins)
//   hz_rs/hz_hit : decode RAW lookup against pending float-file destinations
//   count        : number of stored entries
// Optional build macro FPU_WB_BYPASS_EN: an empty queue with a ready consumer
// forwards in_* straight to out_* in the same cycle without storing the entry.
// The entry struct is sized from fpu_pkg; DATA_W/REG_ADDR_W must match it.
module fpu_wb_queue
    import fpu_pkg::*;
#(
    parameter  int DEPTH      = 4,
    parameter  int DATA_W     = FP_DATA_W,
    parameter  int REG_ADDR_W = FP_REG_ADDR_W,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    fpu_wb_queue_if.slave         wb,
    input  logic                  flush,
    output logic                  ovf_sticky,
    input  logic                  ovf_clr,
    input  logic [REG_ADDR_W-1:0] hz_rs,
    output logic                  hz_hit,
    output logic [CNT_W-1:0]      count
);

    logic [PTR_W-1:0]                    head;
    logic [PTR_W-1:0]                    tail;
    q_state_t                            q_state;
    fp_wb_entry_t                        wr_entry;
    fp_wb_entry_t                        head_entry;
    logic [DATA_W-1:0]                   head_result;
    logic [DEPTH-1:0][FP_REG_ADDR_W-1:0] tap_rd;
    logic [DEPTH-1:0]                    tap_to_int;
    logic [DEPTH-1:0]                    hit_vec;
    logic                                enq;
    logic                                deq;
    logic                                bypass_take;
    logic                                push;
    logic                                pop;
    logic                                unused_ovf;

    assign q_state = queue_state(int'(count), DEPTH);

`ifdef FPU_WB_BYPASS_EN
    assign bypass_take = (q_state == Q_EMPTY) && wb.in_valid && wb.out_ready && !flush;
`else
    assign bypass_take = 1'b0;
`endif

    // in_ready depends only on registered count, never on out_ready.
    assign wb.in_ready = (q_state != Q_FULL);

`ifdef FPU_WB_BYPASS_EN
    assign wb.out_valid = (q_state != Q_EMPTY) || bypass_take;
`else
    assign wb.out_valid = (q_state != Q_EMPTY);
`endif

    assign enq = wb.in_valid && wb.in_ready;
    assign deq = wb.out_valid && wb.out_ready;

    // A bypassed entry is handed over without touching storage; flush wins over both sides.
    assign push = enq && !bypass_take && !flush;
    assign pop  = deq && (q_state != Q_EMPTY) && !flush;

    always_comb begin
        wr_entry        = '0;
        wr_entry.result = wb.in_result;
        wr_entry.rd     = wb.in_rd;
        wr_entry.to_int = wb.in_to_int;
        wr_entry.ovf    = wb.in_ovf;
    end

    fpu_wb_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk        (clk),
        .rstn       (rstn),
        .wr_en      (push),
        .wr_ptr     (tail),
        .wr_data    (wr_entry),
        .rd_ptr     (head),
        .rd_data    (head_entry),
        .tap_rd     (tap_rd),
        .tap_to_int (tap_to_int)
    );

    // The per-entry overflow bit travels with the entry but only the sticky flag consumes it.
    assign unused_ovf  = head_entry.ovf;
    assign head_result = head_entry.result;

    always_comb begin
        wb.out_result = head_result;
        wb.out_rd     = head_entry.rd;
        wb.out_to_int = head_entry.to_int;
`ifdef FPU_WB_BYPASS_EN
        if (bypass_take) begin
            wb.out_result = wb.in_result;
            wb.out_rd     = wb.in_rd;
            wb.out_to_int = wb.in_to_int;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // An input dropped by a same-cycle flush was never accepted, so it does not set the flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_sticky <= 1'b0;
        end else if (enq && wb.in_ovf && !flush) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

    // Slot g holds a live entry when its distance from head (mod DEPTH) is below count;
    // stale storage left behind by dequeues or flush must not raise a hazard.
    for (genvar g = 0; g < DEPTH; g++) begin : g_hit
        logic [PTR_W-1:0] ofs;
        logic             live;
        assign ofs        = PTR_W'(g) - head;
        assign live       = (CNT_W'(ofs) < count);
        assign hit_vec[g] = live && !tap_to_int[g] && (tap_rd[g] == hz_rs);
    end

`ifdef FPU_WB_BYPASS_EN
    assign hz_hit = (|hit_vec) ||
                    (wb.in_valid && !bypass_take && !wb.in_to_int && (wb.in_rd == hz_rs));
`else
    assign hz_hit = |hit_vec;
`endif

endmodule

// File: tb/tb_fpu_wb_queue.sv
module tb_fpu_wb_queue;

    logic       clk;
    logic       rstn;
    logic       flush;
    logic       ovf_clr;
    logic       ovf_sticky;
    logic [4:0] hz_rs;
    logic       hz_hit;
    logic [2:0] count;
    logic       exp_hz_port;

    int n_chk  = 0;
    int n_fail = 0;

    fpu_wb_queue_if #(.DATA_W(32), .REG_ADDR_W(5)) wb ();

    fpu_wb_queue #(
        .DEPTH      (4),
        .DATA_W     (32),
        .REG_ADDR_W (5)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wb         (wb),
        .flush      (flush),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr),
        .hz_rs      (hz_rs),
        .hz_hit     (hz_hit),
        .count      (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                         input logic ovf, input logic ti);
        wb.in_valid  = v;
        wb.in_result = res;
        wb.in_rd     = rd;
        wb.in_ovf    = ovf;
        wb.in_to_int = ti;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn         = 1'b0;
        flush        = 1'b0;
        ovf_clr      = 1'b0;
        hz_rs        = 5'd0;
        wb.out_ready = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        #2;
        chk("rst_count",      32'(count),         32'd0);
        chk("rst_out_valid",  32'(wb.out_valid),  32'd0);
        chk("rst_in_ready",   32'(wb.in_ready),   32'd1);
        chk("rst_sticky",     32'(ovf_sticky),    32'd0);
        chk("rst_out_result", wb.out_result,      32'd0);
        chk("rst_out_rd",     32'(wb.out_rd),     32'd0);
        chk("rst_hz_hit",     32'(hz_hit),        32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // single operation
        drive(1'b1, 32'h3F80_0000, 5'd3, 1'b0, 1'b0);
        wb.out_ready = 1'b1;
        #1;
`ifdef FPU_WB_BYPASS_EN
        chk("byp_out_valid", 32'(wb.out_valid), 32'd1);
        chk("byp_out_rd",    32'(wb.out_rd),    32'd3);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("byp_count",     32'(count),        32'd0);
`else
        chk("single_no_comb", 32'(wb.out_valid), 32'd0);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("single_valid",  32'(wb.out_valid), 32'd1);
        chk("single_rd",     32'(wb.out_rd),    32'd3);
        chk("single_result", wb.out_result,     32'h3F80_0000);
        chk("single_count",  32'(count),        32'd1);
        tick();
        chk("single_drain",  32'(count),        32'd0);
`endif
        chk("single_empty", 32'(wb.out_valid), 32'd0);

        // fill to full, then drain in order while the 5th waits
        wb.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 32'(32'h100 + k), 5'(k), 1'b0, 1'b0);
            #1;
            chk("fill_ready", 32'(wb.in_ready), 32'd1);
            tick();
        end
        drive(1'b1, 32'h105, 5'd5, 1'b0, 1'b0);
        #1;
        chk("fill_count",      32'(count),       32'd4);
        chk("fill_full_ready", 32'(wb.in_ready), 32'd0);
        chk("order_rd1",       32'(wb.out_rd),   32'd1);
        tick();
        chk("fill_hold_count", 32'(count),       32'd4);
        wb.out_ready = 1'b1;
        #1;
        chk("full_enq_deq_ready", 32'(wb.in_ready), 32'd0);
        tick();
        chk("full_deq_count", 32'(count),       32'd3);
        chk("order_rd2",      32'(wb.out_rd),   32'd2);
        chk("after_deq_ready", 32'(wb.in_ready), 32'd1);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("fifth_count", 32'(count),     32'd3);
        chk("order_rd3",   32'(wb.out_rd), 32'd3);
        tick();
        chk("order_rd4",   32'(wb.out_rd), 32'd4);
        chk("drain_cnt2",  32'(count),     32'd2);
        tick();
        chk("order_rd5",   32'(wb.out_rd), 32'd5);
        chk("order_res5",  wb.out_result,  32'h105);
        tick();
        chk("drain_count", 32'(count),        32'd0);
        chk("drain_valid", 32'(wb.out_valid), 32'd0);

        // flush with same-cycle overflowing input, then accept-then-flush
        wb.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'(k), 5'(10 + k), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'hDEAD, 5'd13, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("flush_count",       32'(count),        32'd0);
        chk("flush_valid",       32'(wb.out_valid), 32'd0);
        chk("flush_drop_sticky", 32'(ovf_sticky),   32'd0);
        drive(1'b1, 32'h1, 5'd14, 1'b1, 1'b0);
        #1;
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("acc_count",  32'(count),      32'd1);
        chk("acc_sticky", 32'(ovf_sticky), 32'd1);
        flush = 1'b1;
        #1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush2_count",  32'(count),      32'd0);
        chk("flush2_sticky", 32'(ovf_sticky), 32'd1);

        // ovf_clr alone, then clear and set together
        ovf_clr = 1'b1;
        #1;
        tick();
        ovf_clr = 1'b0;
        #1;
        chk("clr_sticky", 32'(ovf_sticky), 32'd0);
        ovf_clr = 1'b1;
        drive(1'b1, 32'h2, 5'd15, 1'b1, 1'b0);
        #1;
        tick();
        ovf_clr = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("set_wins_sticky", 32'(ovf_sticky), 32'd1);
        chk("set_wins_count",  32'(count),      32'd1);
        flush = 1'b1;
        #1;
        tick();
        flush = 1'b0;

        // hazard lookup
        drive(1'b1, 32'h7, 5'd7, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h9, 5'd9, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        hz_rs = 5'd7;
        #1;
        chk("hz_float_hit", 32'(hz_hit), 32'd1);
        hz_rs = 5'd9;
        #1;
        chk("hz_int_miss", 32'(hz_hit), 32'd0);
        hz_rs = 5'd8;
        drive(1'b1, 32'h0, 5'd8, 1'b0, 1'b0);
`ifdef FPU_WB_BYPASS_EN
        exp_hz_port = 1'b1;
`else
        exp_hz_port = 1'b0;
`endif
        #1;
        chk("hz_in_port", 32'(hz_hit), 32'(exp_hz_port));
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        wb.out_ready = 1'b1;
        #1;
        tick();
        wb.out_ready = 1'b0;
        hz_rs = 5'd7;
        #1;
        chk("hz_stale_miss", 32'(hz_hit), 32'd0);
        chk("hz_count",      32'(count),  32'd1);

        // asynchronous reset with two entries pending
        drive(1'b1, 32'h4, 5'd4, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        hz_rs = 5'd9;
        #1;
        chk("pre_rst_count",  32'(count),      32'd2);
        chk("pre_rst_sticky", 32'(ovf_sticky), 32'd1);
        chk("pre_rst_hz",     32'(hz_hit),     32'd0);
        hz_rs = 5'd4;
        #1;
        chk("pre_rst_hz4",    32'(hz_hit),     32'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_count",  32'(count),         32'd0);
        chk("mid_rst_valid",  32'(wb.out_valid),  32'd0);
        chk("mid_rst_ready",  32'(wb.in_ready),   32'd1);
        chk("mid_rst_rd",     32'(wb.out_rd),     32'd0);
        chk("mid_rst_result", wb.out_result,      32'd0);
        chk("mid_rst_sticky", 32'(ovf_sticky),    32'd0);
        chk("mid_rst_hz",     32'(hz_hit),        32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("post_rst_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
